// File: rtl/vrc_irq_pkg.sv
// Shared constants and types for the VRC-family IRQ units.
package vrc_irq_pkg;

    // PPU dots per scanline, and PPU dots that pass in each M2 cycle.
    localparam int PRESCALER_RELOAD = 341;
    localparam int PRESCALER_STEP   = 3;

    // Bit positions of the control register fields in cpu_data.
    localparam int CTRL_A = 0;  // re-enable value restored on acknowledge
    localparam int CTRL_E = 1;  // counter enable
    localparam int CTRL_M = 2;  // 1: cycle mode, 0: scanline mode

    // Control register image. The field order matches cpu_data[2:0].
    typedef struct packed {
        logic m;
        logic e;
        logic a;
    } irq_ctrl_t;

endpackage

// File: rtl/vrc_irq_prescaler.sv
// Scanline prescaler: counts PPU dots down in M2-sized steps and emits one
// tick per emulated scanline (114,114,113 M2 repeating from reload).
module vrc_irq_prescaler
    import vrc_irq_pkg::*;
#(
    parameter int RELOAD = PRESCALER_RELOAD,
    parameter int STEP   = PRESCALER_STEP
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic reload,
    output logic tick
);

    localparam logic [8:0] RELOAD_V = 9'(RELOAD);
    localparam logic [8:0] STEP_V   = 9'(STEP);
    // Wrapping adds the remainder of a scanline, so the count never leaves 0..RELOAD.
    localparam logic [8:0] WRAP_V   = 9'(RELOAD - STEP);

    logic [8:0] count;

    // A scanline ends when fewer than one step of dots remains.
    assign tick = enable & ~reload & (count <= STEP_V);

    // Dot counter: reload wins, otherwise step down or wrap while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every state register is assigned with <= so all flops sample
        // the same pre-edge values regardless of statement order.
        if (!rst_n) begin
            count <= RELOAD_V;
        end else if (reload) begin
            count <= RELOAD_V;
        end else if (enable) begin
            if (count <= STEP_V) begin
                count <= count + WRAP_V;
            end else begin
                count <= count - STEP_V;
            end
        end
    end

endmodule

// File: rtl/vrc4_irq_unit.sv
// VRC4/VRC6-style IRQ generator: 8-bit up-counter with reload latch, cycle or
// scanline clocking, and a sticky pending flag cleared by control/ack writes.
module vrc4_irq_unit
    import vrc_irq_pkg::*;
#(
    parameter int USE_VRC4_INTERRUPTS = 1,
    parameter int NIBBLE_LATCH        = 1,
    parameter int PRESCALER_RELOAD    = vrc_irq_pkg::PRESCALER_RELOAD,
    parameter int PRESCALER_STEP      = vrc_irq_pkg::PRESCALER_STEP
) (
    input  logic       m2,
    input  logic       not_reset,
    input  logic       wr_latch_lo,
    input  logic       wr_latch_hi,
    input  logic       wr_control,
    input  logic       wr_ack,
    input  logic [7:0] cpu_data,
    output logic       irq_pending,
    output logic [7:0] irq_counter
);

    // Upper data nibble only matters for the 8-bit latch variant.
    logic unused_hi_data;
    assign unused_hi_data = ^cpu_data[7:4];

    generate
        if (USE_VRC4_INTERRUPTS != 0) begin : gen_irq

            logic [7:0] latch;
            logic [7:0] counter;
            logic       pending;
            irq_ctrl_t  ctrl;
            logic       reg_write;
            logic       ps_enable;
            logic       ps_reload;
            logic       ps_tick;
            logic       tick;

            // A control or ack write in a tick cycle swallows that tick.
            assign reg_write = wr_control | wr_ack;
            assign ps_enable = ctrl.e & ~ctrl.m & ~reg_write;
            assign ps_reload = wr_control & cpu_data[CTRL_E];
            assign tick      = ~reg_write & ((ctrl.e & ctrl.m) | ps_tick);

            vrc_irq_prescaler #(
                .RELOAD (PRESCALER_RELOAD),
                .STEP   (PRESCALER_STEP)
            ) u_prescaler (
                .clk    (m2),
                .rst_n  (not_reset),
                .enable (ps_enable),
                .reload (ps_reload),
                .tick   (ps_tick)
            );

            // Reload latch: two nibble writes (VRC4) or one byte write (VRC6).
            always_ff @(posedge m2 or negedge not_reset) begin
                if (!not_reset) begin
                    latch <= 8'h00;
                end else if (NIBBLE_LATCH != 0) begin
                    if (wr_latch_lo) latch[3:0] <= cpu_data[3:0];
                    if (wr_latch_hi) latch[7:4] <= cpu_data[3:0];
                end else if (wr_latch_lo) begin
                    latch <= cpu_data;
                end
            end

            // Control flops; ack restores E from A. Control beats ack.
            always_ff @(posedge m2 or negedge not_reset) begin
                if (!not_reset) begin
                    ctrl <= '0;
                end else if (wr_control) begin
                    ctrl <= irq_ctrl_t'(cpu_data[2:0]);
                end else if (wr_ack) begin
                    ctrl.e <= ctrl.a;
                end
            end

            // Counter: load on enabling control write, count up on tick,
            // reload from the pre-edge latch value on overflow.
            always_ff @(posedge m2 or negedge not_reset) begin
                if (!not_reset) begin
                    counter <= 8'h00;
                end else if (ps_reload) begin
                    counter <= latch;
                end else if (tick) begin
                    counter <= (counter == 8'hFF) ? latch : counter + 8'h01;
                end
            end

            // Pending flag: set on overflow, held until a control or ack write.
            always_ff @(posedge m2 or negedge not_reset) begin
                if (!not_reset) begin
                    pending <= 1'b0;
                end else if (reg_write) begin
                    pending <= 1'b0;
                end else if (tick && counter == 8'hFF) begin
                    pending <= 1'b1;
                end
            end

            assign irq_pending = pending;
            assign irq_counter = counter;

        end else begin : gen_no_irq

            logic unused_inputs;
            assign unused_inputs = ^{m2, not_reset, wr_latch_lo, wr_latch_hi,
                                     wr_control, wr_ack, cpu_data[3:0]};

            assign irq_pending = 1'b0;
            assign irq_counter = 8'h00;

        end
    endgenerate

endmodule

// File: tb/tb_vrc4_irq_unit.sv
// Directed bench for vrc4_irq_unit: a vector table for single-edge behaviour
// plus hand sequences for scanline timing, collisions and async reset.
module tb_vrc4_irq_unit;

    logic       m2 = 1'b0;
    logic       not_reset = 1'b1;
    logic       wr_latch_lo = 1'b0;
    logic       wr_latch_hi = 1'b0;
    logic       wr_control = 1'b0;
    logic       wr_ack = 1'b0;
    logic [7:0] cpu_data = 8'h00;
    logic       irq_pending;
    logic [7:0] irq_counter;
    logic       irq_pending_b;
    logic [7:0] irq_counter_b;

    int total = 0;
    int bad   = 0;

    // VRC4 variant (nibble latch).
    vrc4_irq_unit dut (
        .m2          (m2),
        .not_reset   (not_reset),
        .wr_latch_lo (wr_latch_lo),
        .wr_latch_hi (wr_latch_hi),
        .wr_control  (wr_control),
        .wr_ack      (wr_ack),
        .cpu_data    (cpu_data),
        .irq_pending (irq_pending),
        .irq_counter (irq_counter)
    );

    // VRC6 variant (byte latch), same stimulus.
    vrc4_irq_unit #(.NIBBLE_LATCH(0)) dut_b (
        .m2          (m2),
        .not_reset   (not_reset),
        .wr_latch_lo (wr_latch_lo),
        .wr_latch_hi (wr_latch_hi),
        .wr_control  (wr_control),
        .wr_ack      (wr_ack),
        .cpu_data    (cpu_data),
        .irq_pending (irq_pending_b),
        .irq_counter (irq_counter_b)
    );

    always #5 m2 = ~m2;

    typedef struct {
        logic       lo;
        logic       hi;
        logic       ctl;
        logic       ack;
        logic [7:0] d;
        logic       exp_pend;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one M2 edge and settle just after it.
    task automatic step();
        @(posedge m2);
        #1;
    endtask

    // One-edge strobe pulse.
    task automatic pulse(input logic lo, input logic hi, input logic ctl, input logic ack,
                         input logic [7:0] d);
        wr_latch_lo = lo;
        wr_latch_hi = hi;
        wr_control  = ctl;
        wr_ack      = ack;
        cpu_data    = d;
        step();
        wr_latch_lo = 1'b0;
        wr_latch_hi = 1'b0;
        wr_control  = 1'b0;
        wr_ack      = 1'b0;
        cpu_data    = 8'h00;
    endtask

    // Edges until irq_pending rises, bounded.
    task automatic edges_to_pending(output int n);
        n = 0;
        while (irq_pending !== 1'b1 && n < 300) begin
            step();
            n++;
        end
    endtask

    function automatic vec_t mk(input logic lo, input logic hi, input logic ctl, input logic ack,
                                input logic [7:0] d, input logic p, input logic [7:0] c);
        vec_t v;
        v.lo = lo; v.hi = hi; v.ctl = ctl; v.ack = ack; v.d = d;
        v.exp_pend = p; v.exp_cnt = c;
        return v;
    endfunction

    initial begin
        int n;

        //            lo   hi   ctl  ack  data   pend  cnt
        // Cycle mode: latch FE, control 07.
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h0E, 1'b0, 8'h00);
        vecs[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h0F, 1'b0, 8'h00);
        vecs[2]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h07, 1'b0, 8'hFE);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hFF);
        vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFE);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFE);
        // Ack with A=1: pending clears, tick swallowed, counting resumes.
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'hFE);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hFF);
        vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFE);
        // Scanline mode start, then disable: counter holds.
        vecs[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 1'b0, 8'hFE);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hFE);
        vecs[12] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'hFE);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hFE);
        // Ack with A=0: counting stops, counter holds.
        vecs[14] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h06, 1'b0, 8'hFE);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hFF);
        vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFE);
        vecs[17] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'hFE);
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hFE);
        // Nibble latch: x5 then xA gives A5.
        vecs[19] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h35, 1'b0, 8'hFE);
        vecs[20] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h7A, 1'b0, 8'hFE);
        vecs[21] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 8'hA5);

        // Reset state.
        #1 not_reset = 1'b0;
        #2;
        check("reset_pending", 32'(irq_pending), 32'd0);
        check("reset_counter", 32'(irq_counter), 32'h00);
        #9 not_reset = 1'b1;
        step();

        for (int i = 0; i < 22; i++) begin
            pulse(vecs[i].lo, vecs[i].hi, vecs[i].ctl, vecs[i].ack, vecs[i].d);
            check($sformatf("vec%0d_pending", i), 32'(irq_pending), 32'(vecs[i].exp_pend));
            check($sformatf("vec%0d_counter", i), 32'(irq_counter), 32'(vecs[i].exp_cnt));
        end

        // Byte latch variant: one write of A5, hi strobe ignored.
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 8'h03);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'h02);
        check("byte_latch_counter", 32'(irq_counter_b), 32'hA5);
        check("nibble_latch_counter", 32'(irq_counter), 32'h35);

        // Collisions in cycle mode with latch FF.
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h0F);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 8'h0F);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'h07);
        check("coll_load", 32'(irq_counter), 32'hFF);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("ack_tick_pending", 32'(irq_pending), 32'd0);
        check("ack_tick_counter", 32'(irq_counter), 32'hFF);
        step();
        check("after_ack_overflow", 32'(irq_pending), 32'd1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
        check("latch_hi_on_ovf", 32'(irq_counter), 32'hFF);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("latch_lo_on_ovf", 32'(irq_counter), 32'h1F);
        step();
        check("count_after_reload", 32'(irq_counter), 32'h20);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'h06);
        check("new_latch_value", 32'(irq_counter), 32'h10);
        check("ctrl_clears_pending", 32'(irq_pending), 32'd0);

        // Scanline timing with latch FF: 114 from reload, then 114, 113.
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h0F);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 8'h0F);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'h03);
        edges_to_pending(n);
        check("scanline_first", 32'(n), 32'd114);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        edges_to_pending(n);
        check("scanline_second", 32'(n), 32'd114);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        edges_to_pending(n);
        check("scanline_third", 32'(n), 32'd113);

        // Async reset mid-count with pending set.
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'h03);
        edges_to_pending(n);
        check("pre_reset_pending", 32'(irq_pending), 32'd1);
        repeat (47) step();
        #2 not_reset = 1'b0;
        #1;
        check("async_reset_pending", 32'(irq_pending), 32'd0);
        check("async_reset_counter", 32'(irq_counter), 32'h00);
        #3 not_reset = 1'b1;
        repeat (5) step();
        check("post_reset_hold", 32'(irq_counter), 32'h00);
        // Enable via ack (no prescaler reload) to expose the reset prescaler value.
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        n = 0;
        while (irq_counter !== 8'h01 && n < 300) begin
            step();
            n++;
        end
        check("post_reset_prescaler", 32'(n), 32'd114);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
